fir_tdm_sched: RTL and testbench
================================

FIR_TDM_SCHED -- requirements
Module: fir_tdm_sched

Interface
REQ-001 The block SHALL use parameter NTAPS, default 33, as the number of FIR taps.
REQ-002 The block SHALL use parameter XW, default 21, as the sample and result width (signed).
REQ-003 The block SHALL use parameter SHIFT, default 14, as the coefficient fractional bits.
REQ-004 The block SHALL have port clk, input, 1 bit: clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have ports ch0_valid and ch1_valid, input, 1 bit each: a sample is offered on that channel.
REQ-007 The block SHALL have ports ch0_x and ch1_x, input, XW bits each: signed sample for that channel.
REQ-008 The block SHALL have ports ch0_ready and ch1_ready, output, 1 bit each: a sample is accepted on the cycle where valid and ready are both high.
REQ-009 The block SHALL have port y, output, XW bits: signed filtered result.
REQ-010 The block SHALL have port y_ch, output, 1 bit: the channel that y belongs to.
REQ-011 The block SHALL have port y_valid, output, 1 bit: one-cycle pulse qualifying y and y_ch.
REQ-012 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-013 The block SHALL time-share one signed XW x 16 multiplier and one 43-bit accumulator between two independent NTAPS-tap low-pass FIR channels.
REQ-014 The block SHALL compute y(n) = floor( sum over k=0..NTAPS-1 of C[k]*x(n-k) / 2^SHIFT ), where x(n) is the newest sample.
REQ-015 Coefficients SHALL be C[0..32] = 0,2,8,22,44,76,118,168,226,289,355,424,492,558,620,677,727,770,804,829,845,852,849,838,818,791,756,715,670,619,566,510,453.
REQ-016 Rounding SHALL be an arithmetic right shift of the accumulator by SHIFT (floor toward minus infinity), and y SHALL be accumulator bits [SHIFT+XW-1:SHIFT], wrapping with no saturation.
REQ-017 The state machine SHALL have states CLEAR, IDLE, MAC and OUT.
REQ-018 CLEAR SHALL write zero to history entry i of both channels on sweep cycle i, for i = 0..NTAPS-1, and then go to IDLE.
REQ-019 In IDLE, chN_ready SHALL be high only if chN_valid is high and either the other channel is not valid or the last-granted channel is the other channel.
REQ-020 At most one ready SHALL be high in any cycle.
REQ-021 On acceptance edge E0, the block SHALL write the sample at that channel's write pointer, latch the channel, clear the accumulator and enter MAC.
REQ-022 The write pointer SHALL advance modulo NTAPS after the write, wrapping from 32 to 0.
REQ-023 In MAC, on edges E1..E33, tap k = 0..32 SHALL add C[k] times history[(wp_new - k) mod NTAPS], where wp_new is the slot written at E0.
REQ-024 At edge E33 the block SHALL enter OUT.
REQ-025 At edge E34 the block SHALL register y and y_ch, set y_valid high for exactly one cycle, toggle last_grant to the served channel and return to IDLE.
REQ-026 Latency SHALL be y_valid high in the cycle after E34, and the earliest next acceptance SHALL be E35 (35 cycles per sample).
REQ-027 Each channel's history and write pointer SHALL be touched only by that channel's accepted samples.
REQ-028 While not in IDLE, the block SHALL ignore valid and hold both readies low.
REQ-029 chN_valid SHALL NOT depend combinationally on chN_ready; the design SHALL contain no combinational loop.

Reset
REQ-030 While reset is low: state SHALL be CLEAR with the sweep counter at 0, both write pointers at 0, last_grant at 1 (ch0 wins the first tie), accumulator at 0, y at 0, y_ch at 0, y_valid at 0 and busy at 1.
REQ-031 After reset is released, both readies SHALL stay low for exactly NTAPS cycles (the CLEAR sweep).
REQ-032 Reset asserted in MAC or OUT SHALL abort the computation with no y_valid pulse, and the CLEAR sweep SHALL zero all history.

Structure
REQ-033 Package fir_lp_pkg SHALL hold NTAPS, XW, SHIFT, ACCW=43, coefficient width 16, the coefficient array C, and the state enum.
REQ-034 The block SHALL contain one sub-module, fir_hist_buf: a 2 x NTAPS x XW register-file history with one write port and one read port, addressed by {channel, index}, instantiated once.
REQ-035 The multiplier product SHALL be 37 bits, sign-extended into ACCW.

Verification
REQ-036 Reset release with ch0_valid held high -> ch0_ready low for exactly 33 cycles, then high; first y_valid 35 cycles after acceptance.
REQ-037 ch0 impulse x=16384 followed by zeros -> successive ch0 y = C[0], C[1], ..., C[32] (0, 2, 8, 22, ..., 453), then 0.
REQ-038 ch0 single x=-1 followed by zeros -> y sequence 0, -1, -1, ..., -1 (32 values of -1), then 0; this checks floor rounding.
REQ-039 ch0 constant x=1000000 -> from the 33rd output on, y=1006530.
REQ-040 Both channels valid every cycle, ch0 impulse 16384 and ch1 zeros -> grants ch0, ch1, ch0, ... with y_ch alternating; ch1 y always 0 and ch0 y equal to the C[k] sequence.
REQ-041 Reset pulsed at MAC tap 10 after ch0 x=16384 -> no y_valid, 33-cycle CLEAR, and the next ch0 x=0 -> y=0.

Source files
------------

// File: rtl/fir_lp_pkg.sv
// Shared constants, coefficient table and controller states for the
// two-channel time-shared low-pass FIR.
package fir_lp_pkg;
  localparam int NTAPS = 33;
  localparam int XW    = 21;
  localparam int SHIFT = 14;
  localparam int ACCW  = 43;
  localparam int CW    = 16;
  localparam int PW    = XW + CW;

  typedef enum logic [1:0] {CLEAR, IDLE, MAC, OUT} state_t;

  localparam logic signed [CW-1:0] C [0:NTAPS-1] = '{
    16'sd0,   16'sd2,   16'sd8,   16'sd22,  16'sd44,  16'sd76,  16'sd118,
    16'sd168, 16'sd226, 16'sd289, 16'sd355, 16'sd424, 16'sd492, 16'sd558,
    16'sd620, 16'sd677, 16'sd727, 16'sd770, 16'sd804, 16'sd829, 16'sd845,
    16'sd852, 16'sd849, 16'sd838, 16'sd818, 16'sd791, 16'sd756, 16'sd715,
    16'sd670, 16'sd619, 16'sd566, 16'sd510, 16'sd453
  };
endpackage

// File: rtl/fir_hist_buf.sv
// Sample history for both channels: one write port, one asynchronous read
// port, plus a clear strobe that zeroes one index in both banks at once.
module fir_hist_buf #(
  parameter int NTAPS = 33,
  parameter int XW    = 21
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic                     i_clr,
  input  logic                     i_wch,
  input  logic [$clog2(NTAPS)-1:0] i_widx,
  input  logic [XW-1:0]            i_wdata,
  input  logic                     i_rch,
  input  logic [$clog2(NTAPS)-1:0] i_ridx,
  output logic [XW-1:0]            o_rdata
);
  logic [XW-1:0] r_mem [0:1][0:NTAPS-1];

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_mem[0][i_widx] <= '0;
      r_mem[1][i_widx] <= '0;
    end else if (i_we) begin
      r_mem[i_wch][i_widx] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_rch][i_ridx];
endmodule

// File: rtl/fir_tdm_sched.sv
// Two independent FIR channels sharing one multiplier and accumulator;
// round-robin arbitration on ties, 35 cycles per accepted sample.
module fir_tdm_sched
  import fir_lp_pkg::*;
#(
  parameter int NTAPS = fir_lp_pkg::NTAPS,
  parameter int XW    = fir_lp_pkg::XW,
  parameter int SHIFT = fir_lp_pkg::SHIFT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ch0_valid,
  input  logic          ch1_valid,
  input  logic [XW-1:0] ch0_x,
  input  logic [XW-1:0] ch1_x,
  output logic          ch0_ready,
  output logic          ch1_ready,
  output logic [XW-1:0] y,
  output logic          y_ch,
  output logic          y_valid,
  output logic          busy
);
  localparam int AW = $clog2(NTAPS);

  function automatic logic [AW-1:0] tap_addr(input logic [AW-1:0] wp,
                                             input logic [AW-1:0] k);
    logic [AW:0] s;
    s = {1'b0, wp} + (AW+1)'(NTAPS) - {1'b0, k};
    if (s >= (AW+1)'(NTAPS)) s = s - (AW+1)'(NTAPS);
    return s[AW-1:0];
  endfunction

  function automatic logic [AW-1:0] wp_inc(input logic [AW-1:0] wp);
    return (wp == AW'(NTAPS-1)) ? '0 : wp + 1'b1;
  endfunction

  // Floor of acc / 2^SHIFT, wrapped to XW bits.
  function automatic logic [XW-1:0] round_out(input logic signed [ACCW-1:0] a);
    return a[SHIFT+XW-1:SHIFT];
  endfunction

  state_t                 r_state, w_next_state;
  logic [AW-1:0]          r_cnt;
  logic [AW-1:0]          r_wp0, r_wp1, r_wp_cur;
  logic                   r_ch, r_last_grant;
  logic signed [ACCW-1:0] r_acc;
  logic [XW-1:0]          r_y;
  logic                   r_y_ch, r_y_valid;

  logic                   w_idle, w_accept, w_acc_ch;
  logic [AW-1:0]          w_widx;
  logic [XW-1:0]          w_wdata, w_rdata;
  logic signed [PW-1:0]   w_prod;
  logic signed [ACCW-1:0] w_prod_ext;

  assign w_idle    = (r_state == IDLE);
  assign ch0_ready = w_idle & ch0_valid & (~ch1_valid | r_last_grant);
  assign ch1_ready = w_idle & ch1_valid & (~ch0_valid | ~r_last_grant);
  assign w_accept  = ch0_ready | ch1_ready;
  assign w_acc_ch  = ch1_ready;
  assign w_widx    = (r_state == CLEAR) ? r_cnt : (w_acc_ch ? r_wp1 : r_wp0);
  assign w_wdata   = w_acc_ch ? ch1_x : ch0_x;

  fir_hist_buf #(.NTAPS(NTAPS), .XW(XW)) u_hist (
    .clk     (clk),
    .i_we    (w_accept & reset),
    .i_clr   ((r_state == CLEAR) & reset),
    .i_wch   (w_acc_ch),
    .i_widx  (w_widx),
    .i_wdata (w_wdata),
    .i_rch   (r_ch),
    .i_ridx  (tap_addr(r_wp_cur, r_cnt)),
    .o_rdata (w_rdata)
  );

  assign w_prod     = $signed(w_rdata) * C[r_cnt];
  assign w_prod_ext = {{(ACCW-PW){w_prod[PW-1]}}, w_prod};

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      CLEAR: if (r_cnt == AW'(NTAPS-1)) w_next_state = IDLE;
      IDLE:  if (w_accept)              w_next_state = MAC;
      MAC:   if (r_cnt == AW'(NTAPS-1)) w_next_state = OUT;
      OUT:                              w_next_state = IDLE;
      default:                          w_next_state = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= CLEAR;
      r_cnt        <= '0;
      r_wp0        <= '0;
      r_wp1        <= '0;
      r_wp_cur     <= '0;
      r_ch         <= 1'b0;
      r_last_grant <= 1'b1;
      r_acc        <= '0;
      r_y          <= '0;
      r_y_ch       <= 1'b0;
      r_y_valid    <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_y_valid <= 1'b0;
      case (r_state)
        CLEAR: r_cnt <= (r_cnt == AW'(NTAPS-1)) ? '0 : r_cnt + 1'b1;
        IDLE: if (w_accept) begin
          r_ch     <= w_acc_ch;
          r_wp_cur <= w_acc_ch ? r_wp1 : r_wp0;
          if (w_acc_ch) r_wp1 <= wp_inc(r_wp1);
          else          r_wp0 <= wp_inc(r_wp0);
          r_acc    <= '0;
          r_cnt    <= '0;
        end
        MAC: begin
          r_acc <= r_acc + w_prod_ext;
          r_cnt <= (r_cnt == AW'(NTAPS-1)) ? '0 : r_cnt + 1'b1;
        end
        OUT: begin
          r_y          <= round_out(r_acc);
          r_y_ch       <= r_ch;
          r_y_valid    <= 1'b1;
          r_last_grant <= r_ch;
        end
        default: ;
      endcase
    end
  end

  assign y       = r_y;
  assign y_ch    = r_y_ch;
  assign y_valid = r_y_valid;
  assign busy    = ~w_idle;
endmodule

// File: tb/tb_fir_tdm_sched.sv
// Bench for fir_tdm_sched: directed filter scenarios plus a randomized run,
// all compared against a sample-level reference of both FIR channels.
module tb_fir_tdm_sched;
  localparam int N  = 33;
  localparam int XW = 21;
  localparam int SH = 14;

  logic          clk = 1'b0;
  logic          reset, ch0_valid, ch1_valid;
  logic [XW-1:0] ch0_x, ch1_x;
  logic          ch0_ready, ch1_ready, y_ch, y_valid, busy;
  logic [XW-1:0] y;

  always #5 clk = ~clk;

  fir_tdm_sched dut (
    .clk(clk), .reset(reset),
    .ch0_valid(ch0_valid), .ch1_valid(ch1_valid),
    .ch0_x(ch0_x), .ch1_x(ch1_x),
    .ch0_ready(ch0_ready), .ch1_ready(ch1_ready),
    .y(y), .y_ch(y_ch), .y_valid(y_valid), .busy(busy)
  );

  int coef [N] = '{0, 2, 8, 22, 44, 76, 118, 168, 226, 289, 355, 424, 492,
                   558, 620, 677, 727, 770, 804, 829, 845, 852, 849, 838,
                   818, 791, 756, 715, 670, 619, 566, 510, 453};

  typedef struct { int due; int ch; longint yv; } exp_t;

  int     checks = 0, passed = 0, cyc = 0;
  bit     armed = 0, in_reset = 1;
  int     clr_left = N, busy_left = 0, last_grant = 1;
  longint hist [2][N];
  exp_t   pend [$];
  bit     m_acc0, m_acc1, dut_r0, dut_yv;
  longint log_y [$];
  int     log_ch [$];

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic longint model_y(input int ch);
    longint s;
    longint f;
    logic [XW-1:0] t;
    s = 0;
    for (int k = 0; k < N; k++) s += longint'(coef[k]) * hist[ch][k];
    f = s >>> SH;
    t = f[XW-1:0];
    return longint'($signed(t));
  endfunction

  function automatic bit model_idle();
    return (clr_left == 0) && (busy_left == 0);
  endfunction

  task automatic check_outputs();
    bit exp_v;
    exp_v  = (pend.size() > 0) && (pend[0].due == cyc);
    dut_yv = y_valid;
    if (!armed) return;
    check("y_valid", longint'(y_valid), longint'(exp_v));
    check("busy", longint'(busy), longint'(!model_idle()));
    if (in_reset) begin
      check("rst_y", longint'($signed(y)), 0);
      check("rst_y_ch", longint'(y_ch), 0);
    end
    if (exp_v) begin
      check("y", longint'($signed(y)), pend[0].yv);
      check("y_ch", longint'(y_ch), longint'(pend[0].ch));
      void'(pend.pop_front());
    end
    if (y_valid) begin
      log_y.push_back(longint'($signed(y)));
      log_ch.push_back(int'(y_ch));
    end
  endtask

  task automatic step(input bit rst_n, input bit v0, input longint x0,
                      input bit v1, input longint x1);
    bit idle;
    @(negedge clk);
    check_outputs();
    reset = rst_n; ch0_valid = v0; ch1_valid = v1;
    ch0_x = x0[XW-1:0]; ch1_x = x1[XW-1:0];
    #1;
    idle   = model_idle();
    m_acc0 = idle && v0 && (!v1 || last_grant == 1);
    m_acc1 = idle && v1 && (!v0 || last_grant == 0);
    dut_r0 = ch0_ready;
    if (armed) begin
      check("ch0_ready", longint'(ch0_ready), longint'(m_acc0));
      check("ch1_ready", longint'(ch1_ready), longint'(m_acc1));
    end
    @(posedge clk);
    cyc++;
    in_reset = !rst_n;
    if (!rst_n) begin
      clr_left = N; busy_left = 0; last_grant = 1;
      pend.delete();
      for (int c = 0; c < 2; c++) for (int k = 0; k < N; k++) hist[c][k] = 0;
    end else if (clr_left > 0) begin
      clr_left--;
    end else begin
      if (busy_left > 0) busy_left--;
      if (m_acc0 || m_acc1) begin
        int ch;
        ch = m_acc1 ? 1 : 0;
        for (int k = N-1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
        hist[ch][0] = longint'($signed(ch ? ch1_x : ch0_x));
        pend.push_back('{due: cyc + 34, ch: ch, yv: model_y(ch)});
        busy_left  = 34;
        last_grant = ch;
      end
    end
    armed = 1;
  endtask

  task automatic send0(input longint x);
    int n;
    n = 0;
    do begin step(1, 1, x, 0, 0); n++; end while (!m_acc0 && n < 100);
    if (!m_acc0) check("send0_timeout", n, 0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  // Count cycles with ch0 held valid until the DUT raises ch0_ready.
  task automatic clear_len_check(input longint x);
    int n;
    n = 0;
    step(1, 1, x, 0, 0);
    while (!dut_r0 && n < 100) begin n++; step(1, 1, x, 0, 0); end
    check("clear_len", n, 33);
  endtask

  initial begin
    int n, i0, i1;
    reset = 0; ch0_valid = 0; ch1_valid = 0; ch0_x = '0; ch1_x = '0;
    do_reset(4);

    // Release with ch0 valid, then latency of the first result.
    log_y.delete();
    clear_len_check(0);
    n = 0;
    do begin step(1, 0, 0, 0, 0); n++; end while (!dut_yv && n < 100);
    check("first_latency", n, 35);
    idle_cycles(2);

    // Impulse response on ch0.
    log_y.delete();
    send0(16384);
    for (int i = 0; i < N; i++) send0(0);
    idle_cycles(40);
    check("imp_count", log_y.size(), 34);
    for (int k = 0; k < log_y.size() && k < 34; k++)
      check("imp_tap", log_y[k], (k < N) ? longint'(coef[k]) : 0);

    // Floor rounding of a tiny negative input.
    log_y.delete();
    send0(-1);
    for (int i = 0; i < N; i++) send0(0);
    idle_cycles(40);
    check("neg_count", log_y.size(), 34);
    for (int k = 0; k < log_y.size() && k < 34; k++)
      check("neg_floor", log_y[k], (k == 0 || k == 33) ? 0 : -1);

    // DC gain.
    log_y.delete();
    for (int i = 0; i < 40; i++) send0(1000000);
    idle_cycles(40);
    check("dc_count", log_y.size(), 40);
    for (int k = 32; k < log_y.size(); k++) check("dc_gain", log_y[k], 1006530);

    // Both channels saturating the scheduler.
    do_reset(2);
    for (int i = 0; i < N; i++) step(1, 0, 0, 0, 0);
    log_y.delete(); log_ch.delete();
    i0 = 0; i1 = 0; n = 0;
    while ((i0 < 34 || i1 < 34) && n < 5000) begin
      step(1, i0 < 34, (i0 == 0) ? 16384 : 0, i1 < 34, 0);
      if (m_acc0) i0++;
      if (m_acc1) i1++;
      n++;
    end
    idle_cycles(40);
    check("dual_count", log_y.size(), 68);
    for (int k = 0; k < log_y.size() && k < 68; k++) begin
      check("dual_ych", log_ch[k], k % 2);
      check("dual_y", log_y[k], (k % 2 == 0 && k / 2 < N) ? longint'(coef[k/2]) : 0);
    end

    // Reset in the middle of a computation.
    send0(16384);
    idle_cycles(10);
    log_y.delete();
    do_reset(2);
    clear_len_check(0);
    idle_cycles(40);
    check("abort_count", log_y.size(), 1);
    if (log_y.size() > 0) check("abort_y", log_y[0], 0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      logic [XW-1:0] r0, r1;
      bit rn;
      r0 = XW'($urandom()); r1 = XW'($urandom());
      rn = ($urandom_range(0, 399) != 0);
      step(rn, $urandom_range(0, 3) != 0, longint'($signed(r0)),
           $urandom_range(0, 3) != 0, longint'($signed(r1)));
    end
    idle_cycles(80);
    check("pending_drained", pend.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
